// File: rtl/op_prefix_call_sequencer_pkg.sv
// Shared types for the 11xx1101 opcode-group sequencer: FSM states and
// bus/index/address select encodings.
package op_prefix_call_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_RST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_RD_LO,
    ST_RD_HI,
    ST_WR_HI,
    ST_WR_LO,
    ST_JUMP,
    ST_EXEC
  } state_e;

  typedef enum logic [1:0] {
    CYC_M1 = 2'b00,
    CYC_MR = 2'b01,
    CYC_MW = 2'b10
  } cyc_type_e;

  typedef enum logic [1:0] {
    IDX_HL = 2'b00,
    IDX_IX = 2'b01,
    IDX_IY = 2'b10
  } idx_sel_e;

  typedef enum logic {
    ADDR_PC = 1'b0,
    ADDR_SP = 1'b1
  } addr_sel_e;

endpackage

// File: rtl/op_prefix_call_sequencer_state_reg.sv
// Prefix state carried across chained DD/FD/ED opcodes: index select,
// ED page flag and a saturating count of consecutive prefixes.
module op_prefix_state_reg
  import op_prefix_call_sequencer_pkg::*;
#(
  parameter int unsigned PREFIX_CNT_W = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    set_ix_i,
  input  logic                    set_iy_i,
  input  logic                    set_ed_i,
  input  logic                    clear_i,
  output logic [1:0]              idx_sel_o,
  output logic                    ed_page_o,
  output logic [PREFIX_CNT_W-1:0] prefix_run_o
);

  idx_sel_e                idx_q, idx_d;
  logic                    ed_q, ed_d;
  logic [PREFIX_CNT_W-1:0] run_q, run_d;

  // Last prefix wins; ED drops any pending DD/FD index selection.
  always_comb begin
    idx_d = idx_q;
    ed_d  = ed_q;
    run_d = run_q;
    if (clear_i) begin
      idx_d = IDX_HL;
      ed_d  = 1'b0;
      run_d = '0;
    end else begin
      if (set_ix_i) begin
        idx_d = IDX_IX;
        ed_d  = 1'b0;
      end else if (set_iy_i) begin
        idx_d = IDX_IY;
        ed_d  = 1'b0;
      end else if (set_ed_i) begin
        idx_d = IDX_HL;
        ed_d  = 1'b1;
      end
      if ((set_ix_i || set_iy_i || set_ed_i) && (run_q != '1)) begin
        run_d = run_q + PREFIX_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idx_q <= IDX_HL;
      ed_q  <= 1'b0;
      run_q <= '0;
    end else begin
      idx_q <= idx_d;
      ed_q  <= ed_d;
      run_q <= run_d;
    end
  end

  assign idx_sel_o    = idx_q;
  assign ed_page_o    = ed_q;
  assign prefix_run_o = run_q;

endmodule

// File: rtl/op_prefix_call_sequencer.sv
// M-cycle sequencer for the 11xx1101 group (CALL nn, DD, ED, FD): drives the
// group decoder, runs the CALL bus sequence and hands other opcodes on.
module op_prefix_call_sequencer
  import op_prefix_call_sequencer_pkg::*;
#(
  parameter int unsigned PREFIX_CNT_W = 4
) (
  input  logic                    CLK,
  input  logic                    notReset,
  input  logic                    grp_match,
  input  logic                    P2_Set_ICALLnn_0,
  input  logic                    P2_Set_XIX,
  input  logic                    P2_Set_XOTR,
  input  logic                    P2_Set_XIY,
  input  logic                    P2_Set_CMR,
  input  logic                    P2_Set_CM1,
  input  logic                    cyc_ack,
  input  logic                    exec_done,
  output logic                    dec_enable,
  output logic                    cyc_req,
  output logic [1:0]              cyc_type,
  output logic                    addr_sel,
  output logic                    pc_inc,
  output logic                    sp_dec,
  output logic                    z_load,
  output logic                    w_load,
  output logic                    wdata_sel,
  output logic                    pc_load_wz,
  output logic                    exec_start,
  output logic [1:0]              idx_sel,
  output logic                    ed_page,
  output logic                    int_allow,
  output logic [PREFIX_CNT_W-1:0] prefix_run
);

  state_e    state_q;
  logic      cyc_req_q;
  cyc_type_e cyc_type_q;
  addr_sel_e addr_sel_q;
  logic      wdata_sel_q;
  logic      pc_inc_q, sp_dec_q, z_load_q, w_load_q, pc_load_wz_q, exec_start_q;

  logic do_call, set_ix, set_iy, set_ed, do_prefix, clear_prefix;

  // Decoder outputs are only trusted in DECODE; priority CALL > DD > FD > ED.
  always_comb begin
    do_call = 1'b0;
    set_ix  = 1'b0;
    set_iy  = 1'b0;
    set_ed  = 1'b0;
    if ((state_q == ST_DECODE) && grp_match) begin
      if (P2_Set_ICALLnn_0 && P2_Set_CMR) begin
        do_call = 1'b1;
      end else if (P2_Set_CM1) begin
        if (P2_Set_XIX)       set_ix = 1'b1;
        else if (P2_Set_XIY)  set_iy = 1'b1;
        else if (P2_Set_XOTR) set_ed = 1'b1;
      end
    end
  end

  assign do_prefix    = set_ix || set_iy || set_ed;
  assign clear_prefix = (state_q == ST_JUMP) || ((state_q == ST_EXEC) && exec_done);

  op_prefix_state_reg #(
    .PREFIX_CNT_W(PREFIX_CNT_W)
  ) u_prefix (
    .clk_i        (CLK),
    .rst_ni       (notReset),
    .set_ix_i     (set_ix),
    .set_iy_i     (set_iy),
    .set_ed_i     (set_ed),
    .clear_i      (clear_prefix),
    .idx_sel_o    (idx_sel),
    .ed_page_o    (ed_page),
    .prefix_run_o (prefix_run)
  );

  always_ff @(posedge CLK) begin
    if (!notReset) begin
      state_q      <= ST_RST_IDLE;
      cyc_req_q    <= 1'b0;
      cyc_type_q   <= CYC_M1;
      addr_sel_q   <= ADDR_PC;
      wdata_sel_q  <= 1'b0;
      pc_inc_q     <= 1'b0;
      sp_dec_q     <= 1'b0;
      z_load_q     <= 1'b0;
      w_load_q     <= 1'b0;
      pc_load_wz_q <= 1'b0;
      exec_start_q <= 1'b0;
    end else begin
      pc_inc_q     <= 1'b0;
      sp_dec_q     <= 1'b0;
      z_load_q     <= 1'b0;
      w_load_q     <= 1'b0;
      pc_load_wz_q <= 1'b0;
      exec_start_q <= 1'b0;
      unique case (state_q)
        ST_RST_IDLE: begin
          state_q    <= ST_FETCH;
          cyc_req_q  <= 1'b1;
          cyc_type_q <= CYC_M1;
          addr_sel_q <= ADDR_PC;
        end
        ST_FETCH: begin
          if (cyc_ack) begin
            state_q   <= ST_DECODE;
            cyc_req_q <= 1'b0;
            pc_inc_q  <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (do_call) begin
            state_q    <= ST_RD_LO;
            cyc_req_q  <= 1'b1;
            cyc_type_q <= CYC_MR;
            addr_sel_q <= ADDR_PC;
          end else if (do_prefix) begin
            state_q    <= ST_FETCH;
            cyc_req_q  <= 1'b1;
            cyc_type_q <= CYC_M1;
            addr_sel_q <= ADDR_PC;
          end else begin
            state_q      <= ST_EXEC;
            exec_start_q <= 1'b1;
          end
        end
        ST_RD_LO: begin
          if (cyc_ack) begin
            state_q  <= ST_RD_HI;
            z_load_q <= 1'b1;
            pc_inc_q <= 1'b1;
          end
        end
        ST_RD_HI: begin
          if (cyc_ack) begin
            state_q     <= ST_WR_HI;
            w_load_q    <= 1'b1;
            pc_inc_q    <= 1'b1;
            cyc_req_q   <= 1'b0;
            cyc_type_q  <= CYC_MW;
            addr_sel_q  <= ADDR_SP;
            wdata_sel_q <= 1'b0;
            sp_dec_q    <= 1'b1;
          end
        end
        // Request is raised one cycle after entry so SP-1 settles first.
        ST_WR_HI: begin
          if (!cyc_req_q) begin
            cyc_req_q <= 1'b1;
          end else if (cyc_ack) begin
            state_q     <= ST_WR_LO;
            cyc_req_q   <= 1'b0;
            sp_dec_q    <= 1'b1;
            wdata_sel_q <= 1'b1;
          end
        end
        ST_WR_LO: begin
          if (!cyc_req_q) begin
            cyc_req_q <= 1'b1;
          end else if (cyc_ack) begin
            state_q      <= ST_JUMP;
            cyc_req_q    <= 1'b0;
            pc_load_wz_q <= 1'b1;
          end
        end
        ST_JUMP: begin
          state_q     <= ST_FETCH;
          cyc_req_q   <= 1'b1;
          cyc_type_q  <= CYC_M1;
          addr_sel_q  <= ADDR_PC;
          wdata_sel_q <= 1'b0;
        end
        ST_EXEC: begin
          if (exec_done) begin
            state_q    <= ST_FETCH;
            cyc_req_q  <= 1'b1;
            cyc_type_q <= CYC_M1;
            addr_sel_q <= ADDR_PC;
          end
        end
        default: begin
          state_q   <= ST_RST_IDLE;
          cyc_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign dec_enable = (state_q == ST_DECODE) && grp_match;
  assign int_allow  = (state_q == ST_FETCH) && (idx_sel == IDX_HL) && !ed_page;
  assign cyc_req    = cyc_req_q;
  assign cyc_type   = cyc_type_q;
  assign addr_sel   = addr_sel_q;
  assign wdata_sel  = wdata_sel_q;
  assign pc_inc     = pc_inc_q;
  assign sp_dec     = sp_dec_q;
  assign z_load     = z_load_q;
  assign w_load     = w_load_q;
  assign pc_load_wz = pc_load_wz_q;
  assign exec_start = exec_start_q;

endmodule

// File: tb/tb_op_prefix_call_sequencer.sv
// Directed bench for op_prefix_call_sequencer: per-cycle vector table plus
// hand-written wait-state, mid-cycle reset and saturation sequences.
module tb_op_prefix_call_sequencer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       notReset, grp_match, icall, xix, xotr, xiy, cmr, cm1, cyc_ack, exec_done;
  logic       dec_enable, cyc_req, addr_sel, pc_inc, sp_dec, z_load, w_load;
  logic       wdata_sel, pc_load_wz, exec_start, ed_page, int_allow;
  logic [1:0] cyc_type, idx_sel;
  logic [3:0] prefix_run;

  op_prefix_call_sequencer #(.PREFIX_CNT_W(4)) dut (
    .CLK(CLK), .notReset(notReset), .grp_match(grp_match),
    .P2_Set_ICALLnn_0(icall), .P2_Set_XIX(xix), .P2_Set_XOTR(xotr), .P2_Set_XIY(xiy),
    .P2_Set_CMR(cmr), .P2_Set_CM1(cm1), .cyc_ack(cyc_ack), .exec_done(exec_done),
    .dec_enable(dec_enable), .cyc_req(cyc_req), .cyc_type(cyc_type), .addr_sel(addr_sel),
    .pc_inc(pc_inc), .sp_dec(sp_dec), .z_load(z_load), .w_load(w_load),
    .wdata_sel(wdata_sel), .pc_load_wz(pc_load_wz), .exec_start(exec_start),
    .idx_sel(idx_sel), .ed_page(ed_page), .int_allow(int_allow), .prefix_run(prefix_run)
  );

  // Input word: {notReset, grp, icall, xix, xiy, xotr, cmr, cm1, ack, done}
  localparam logic [9:0] I_RST  = 10'b0000000000;
  localparam logic [9:0] I_IDLE = 10'b1000000000;
  localparam logic [9:0] I_ACK  = 10'b1000000010;
  localparam logic [9:0] I_DONE = 10'b1000000001;
  localparam logic [9:0] I_CALL = 10'b1110001000;
  localparam logic [9:0] I_DD   = 10'b1101000100;
  localparam logic [9:0] I_FD   = 10'b1100100100;
  localparam logic [9:0] I_ED   = 10'b1100010100;

  typedef struct {
    logic [9:0]  in;
    logic [19:0] exp;
  } vec_t;

  vec_t        tv[$];
  int unsigned n_err = 0;
  int unsigned n_chk = 0;
  int unsigned cnt_z, cnt_w, cnt_sp, cnt_pcl, cnt_pci;

  // Output word: {dec_en, req, type, addr, pc_inc, sp_dec, z, w, wdata, pcl, xs, idx, ed, ia, run}
  function automatic logic [19:0] E(logic de, logic rq, logic [1:0] ty, logic as, logic pi,
                                    logic sd, logic zl, logic wl, logic wd, logic pl, logic xs,
                                    logic [1:0] ix, logic ed, logic ia, logic [3:0] run);
    return {de, rq, ty, as, pi, sd, zl, wl, wd, pl, xs, ix, ed, ia, run};
  endfunction

  function automatic logic [19:0] act();
    return {dec_enable, cyc_req, cyc_type, addr_sel, pc_inc, sp_dec, z_load, w_load,
            wdata_sel, pc_load_wz, exec_start, idx_sel, ed_page, int_allow, prefix_run};
  endfunction

  task automatic drive(input logic [9:0] v);
    {notReset, grp_match, icall, xix, xiy, xotr, cmr, cm1, cyc_ack, exec_done} = v;
  endtask

  task automatic add(input logic [9:0] i, input logic [19:0] e);
    vec_t v;
    v.in  = i;
    v.exp = e;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [19:0] a, input logic [19:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %05h expected %05h", nm, a, e);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (z_load)     cnt_z++;
    if (w_load)     cnt_w++;
    if (sp_dec)     cnt_sp++;
    if (pc_load_wz) cnt_pcl++;
    if (pc_inc)     cnt_pci++;
  endtask

  task automatic do_access(input string nm, input logic [1:0] ty);
    int unsigned n = 0;
    while (cyc_req !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk({nm, "_req"}, 20'(cyc_req), 20'd1);
    for (int k = 0; k < 3; k++) begin
      chk({nm, "_wait"}, {17'd0, cyc_req, cyc_type}, {17'd0, 1'b1, ty});
      tick();
    end
    cyc_ack = 1'b1;
    tick();
    cyc_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset then CALL nn, zero-wait acks
    add(I_IDLE, E(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    add(I_ACK,  E(0,1,0,0,0,0,0,0,0,0,0,0,0,1,0));
    add(I_CALL, E(1,0,0,0,1,0,0,0,0,0,0,0,0,0,0));
    add(I_ACK,  E(0,1,1,0,0,0,0,0,0,0,0,0,0,0,0));
    add(I_ACK,  E(0,1,1,0,1,0,1,0,0,0,0,0,0,0,0));
    add(I_ACK,  E(0,0,2,1,1,1,0,1,0,0,0,0,0,0,0));
    add(I_ACK,  E(0,1,2,1,0,0,0,0,0,0,0,0,0,0,0));
    add(I_IDLE, E(0,0,2,1,0,1,0,0,1,0,0,0,0,0,0));
    add(I_ACK,  E(0,1,2,1,0,0,0,0,1,0,0,0,0,0,0));
    add(I_IDLE, E(0,0,2,1,0,0,0,0,1,1,0,0,0,0,0));
    add(I_IDLE, E(0,1,0,0,0,0,0,0,0,0,0,0,0,1,0));
    // DD DD FD 21
    add(I_ACK,  E(0,1,0,0,0,0,0,0,0,0,0,0,0,1,0));
    add(I_DD,   E(1,0,0,0,1,0,0,0,0,0,0,0,0,0,0));
    add(I_IDLE, E(0,1,0,0,0,0,0,0,0,0,0,1,0,0,1));
    add(I_ACK,  E(0,1,0,0,0,0,0,0,0,0,0,1,0,0,1));
    add(I_DD,   E(1,0,0,0,1,0,0,0,0,0,0,1,0,0,1));
    add(I_ACK,  E(0,1,0,0,0,0,0,0,0,0,0,1,0,0,2));
    add(I_FD,   E(1,0,0,0,1,0,0,0,0,0,0,1,0,0,2));
    add(I_ACK,  E(0,1,0,0,0,0,0,0,0,0,0,2,0,0,3));
    add(I_IDLE, E(0,0,0,0,1,0,0,0,0,0,0,2,0,0,3));
    add(I_IDLE, E(0,0,0,0,0,0,0,0,0,0,1,2,0,0,3));
    add(I_DONE, E(0,0,0,0,0,0,0,0,0,0,0,2,0,0,3));
    add(I_IDLE, E(0,1,0,0,0,0,0,0,0,0,0,0,0,1,0));
    // DD ED 4B, exec_done together with exec_start
    add(I_ACK,  E(0,1,0,0,0,0,0,0,0,0,0,0,0,1,0));
    add(I_DD,   E(1,0,0,0,1,0,0,0,0,0,0,0,0,0,0));
    add(I_ACK,  E(0,1,0,0,0,0,0,0,0,0,0,1,0,0,1));
    add(I_ED,   E(1,0,0,0,1,0,0,0,0,0,0,1,0,0,1));
    add(I_ACK,  E(0,1,0,0,0,0,0,0,0,0,0,0,1,0,2));
    add(I_IDLE, E(0,0,0,0,1,0,0,0,0,0,0,0,1,0,2));
    add(I_DONE, E(0,0,0,0,0,0,0,0,0,0,1,0,1,0,2));
    add(I_IDLE, E(0,1,0,0,0,0,0,0,0,0,0,0,0,1,0));
    // DD CD: prefixed CALL runs as plain CALL and clears the prefix
    add(I_ACK,  E(0,1,0,0,0,0,0,0,0,0,0,0,0,1,0));
    add(I_DD,   E(1,0,0,0,1,0,0,0,0,0,0,0,0,0,0));
    add(I_ACK,  E(0,1,0,0,0,0,0,0,0,0,0,1,0,0,1));
    add(I_CALL, E(1,0,0,0,1,0,0,0,0,0,0,1,0,0,1));
    add(I_ACK,  E(0,1,1,0,0,0,0,0,0,0,0,1,0,0,1));
    add(I_ACK,  E(0,1,1,0,1,0,1,0,0,0,0,1,0,0,1));
    add(I_IDLE, E(0,0,2,1,1,1,0,1,0,0,0,1,0,0,1));
    add(I_ACK,  E(0,1,2,1,0,0,0,0,0,0,0,1,0,0,1));
    add(I_IDLE, E(0,0,2,1,0,1,0,0,1,0,0,1,0,0,1));
    add(I_ACK,  E(0,1,2,1,0,0,0,0,1,0,0,1,0,0,1));
    add(I_IDLE, E(0,0,2,1,0,0,0,0,1,1,0,1,0,0,1));
    add(I_IDLE, E(0,1,0,0,0,0,0,0,0,0,0,0,0,1,0));

    drive(I_RST);
    @(posedge CLK);
    foreach (tv[i]) begin
      @(negedge CLK);
      drive(tv[i].in);
      #1;
      chk($sformatf("vec%0d", i), act(), tv[i].exp);
    end

    // CALL with three wait cycles on every bus access
    cnt_z = 0; cnt_w = 0; cnt_sp = 0; cnt_pcl = 0; cnt_pci = 0;
    drive(I_IDLE);
    do_access("m1", 2'b00);
    drive(I_CALL);
    cyc_ack = 1'b1;
    #1;
    chk("stray_ack_decode", 20'(dec_enable), 20'd1);
    tick();
    drive(I_IDLE);
    do_access("mr_lo", 2'b01);
    do_access("mr_hi", 2'b01);
    do_access("mw_hi", 2'b10);
    do_access("mw_lo", 2'b10);
    tick();
    chk("wait_z_count",   20'(cnt_z),   20'd1);
    chk("wait_w_count",   20'(cnt_w),   20'd1);
    chk("wait_sp_count",  20'(cnt_sp),  20'd2);
    chk("wait_pcl_count", 20'(cnt_pcl), 20'd1);
    chk("wait_pci_count", 20'(cnt_pci), 20'd3);
    chk("wait_back_fetch", {17'd0, cyc_req, cyc_type}, {17'd0, 1'b1, 2'b00});

    // Reset asserted in RD_HI with a DD prefix pending
    drive(I_ACK);  tick();
    drive(I_DD);   tick();
    drive(I_ACK);  tick();
    drive(I_CALL); tick();
    drive(I_ACK);  tick();
    drive(I_IDLE);
    #1;
    chk("rd_hi_reached", {16'd0, cyc_req, cyc_type, z_load}, {16'd0, 1'b1, 2'b01, 1'b1});
    drive(I_RST);
    tick();
    chk("mid_reset_outputs", act(), 20'd0);
    drive(I_IDLE);
    #1;
    chk("release_cycle1_idle", 20'(cyc_req), 20'd0);
    tick();
    chk("release_cycle2_fetch", {16'd0, cyc_req, cyc_type, int_allow}, {16'd0, 1'b1, 2'b00, 1'b1});

    // 20 consecutive FD prefixes: counter saturates, never wraps
    for (int i = 0; i < 20; i++) begin
      int unsigned want;
      drive(I_ACK); tick();
      drive(I_FD);  tick();
      drive(I_IDLE);
      want = (i + 1 > 15) ? 15 : i + 1;
      chk($sformatf("fd_run%0d", i), {14'd0, idx_sel, prefix_run}, {14'd0, 2'b10, 4'(want)});
    end
    drive(I_ACK);  tick();
    drive(I_IDLE); tick();
    drive(I_DONE); tick();
    drive(I_IDLE);
    chk("fd_cleared", {14'd0, idx_sel, prefix_run}, 20'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
